// File: rtl/gpio_cmd_engine.sv
// GPIO-driven command engine: fetch one BRAM element, apply read/complement/offset/multiply.
// Define GPIO_CMD_WRITEBACK_EN to write non-read results back to the same BRAM address.
module gpio_cmd_engine #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned NUM_ELEM  = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned STRIDE    = 4,
  parameter int unsigned BRAM_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W+4:0]  gpio_cmdreg,
  input  logic [7:0]        gpio_mult,
  input  logic [7:0]        gpio_offset,
  input  logic [DATA_W-1:0] bram_rd,
  output logic [31:0]       bram_adr,
  output logic              bram_en,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_wd,
  output logic [DATA_W-1:0] gpio_rd,
  output logic [2:0]        gpio_status
);

  localparam int unsigned CNT_W = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StExec,
    StWb,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Input synchronisers; go gets a third stage for edge detection.
  logic [IDX_W+4:0] cmd_s1, cmd_s2;
  logic [7:0]       mult_s1, mult_s2;
  logic [7:0]       off_s1, off_s2;
  logic             go_s3;

  logic             go, go_rise, idx_legal;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       op_s;
  logic [31:0]      adr_calc;
  logic             unused_rsvd;

  logic [1:0]        op_q, op_d;
  logic [7:0]        mult_q, mult_d;
  logic [7:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       adr_q, adr_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] result;
  logic              do_wb;

  assign go          = cmd_s2[0];
  assign go_rise     = go & ~go_s3;
  assign idx_s       = cmd_s2[IDX_W+2:3];
  assign op_s        = cmd_s2[IDX_W+4:IDX_W+3];
  assign idx_legal   = 32'(idx_s) < NUM_ELEM;
  assign adr_calc    = BASE_ADDR + 32'(idx_s) * STRIDE;
  assign unused_rsvd = ^cmd_s2[2:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_s1  <= '0;
      cmd_s2  <= '0;
      mult_s1 <= '0;
      mult_s2 <= '0;
      off_s1  <= '0;
      off_s2  <= '0;
      go_s3   <= 1'b0;
    end else begin
      cmd_s1  <= gpio_cmdreg;
      cmd_s2  <= cmd_s1;
      mult_s1 <= gpio_mult;
      mult_s2 <= mult_s1;
      off_s1  <= gpio_offset;
      off_s2  <= off_s1;
      go_s3   <= cmd_s2[0];
    end
  end

  always_comb begin
    result = bram_rd;
    unique case (op_q)
      2'b00: result = bram_rd;
      2'b01: result = ~bram_rd;
      2'b10: result = bram_rd + DATA_W'(off_q);
      2'b11: result = bram_rd * DATA_W'(mult_q);
      default: result = bram_rd;
    endcase
  end

`ifdef GPIO_CMD_WRITEBACK_EN
  logic [DATA_W-1:0] wd_q, wd_d;

  assign do_wb   = (op_q != 2'b00);
  assign bram_we = (state_q == StWb);
  assign bram_wd = wd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  always_comb begin
    wd_d = wd_q;
    if (state_q == StExec && do_wb) begin
      wd_d = result;
    end
  end
`else
  assign do_wb   = 1'b0;
  assign bram_we = 1'b0;
  assign bram_wd = '0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mult_d  = mult_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (go_rise) begin
          op_d   = op_s;
          mult_d = mult_s2;
          off_d  = off_s2;
          done_d = 1'b0;
          err_d  = 1'b0;
          if (idx_legal) begin
            busy_d  = 1'b1;
            adr_d   = adr_calc;
            state_d = StFetch;
          end else begin
            // Illegal index completes at once without touching the BRAM.
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        cnt_d   = '0;
        state_d = (BRAM_LAT == 1) ? StExec : StWait;
      end
      StWait: begin
        if (cnt_q == CNT_W'(BRAM_LAT - 2)) begin
          state_d = StExec;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StExec: begin
        rd_d = result;
        if (do_wb) begin
          state_d = StWb;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StWb: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (!go) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      mult_q  <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      adr_q   <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mult_q  <= mult_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bram_en     = (state_q == StFetch) || (state_q == StWb);
  assign bram_adr    = adr_q;
  assign gpio_rd     = rd_q;
  assign gpio_status = {err_q, done_q, busy_q};

endmodule

// File: tb/tb_gpio_cmd_engine.sv
// Directed bench for gpio_cmd_engine: instance 0 uses defaults, instance 1 has
// NUM_ELEM=6 and BRAM_LAT=3. Expected results flow through a scoreboard queue.
module tb_gpio_cmd_engine;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic [7:0]  cmd   [2];
  logic [7:0]  mult  [2];
  logic [7:0]  off   [2];
  logic [31:0] rd_in [2];
  logic [31:0] adr   [2];
  logic        en    [2];
  logic        we    [2];
  logic [31:0] wd    [2];
  logic [31:0] grd   [2];
  logic [2:0]  st    [2];

  logic [31:0] mem [2][8];
  logic [31:0] q1a, q1b;
  int          fcnt [2] = '{0, 0};
  int          wcnt [2] = '{0, 0};
  logic [31:0] wadr [2];
  logic [31:0] wdat [2];

  typedef struct packed {
    logic [31:0] rd;
    logic [2:0]  st;
  } exp_t;
  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpio_cmd_engine u0 (
    .clk(clk), .reset(rst_n[0]), .gpio_cmdreg(cmd[0]), .gpio_mult(mult[0]),
    .gpio_offset(off[0]), .bram_rd(rd_in[0]), .bram_adr(adr[0]), .bram_en(en[0]),
    .bram_we(we[0]), .bram_wd(wd[0]), .gpio_rd(grd[0]), .gpio_status(st[0])
  );

  gpio_cmd_engine #(.NUM_ELEM(6), .BRAM_LAT(3)) u1 (
    .clk(clk), .reset(rst_n[1]), .gpio_cmdreg(cmd[1]), .gpio_mult(mult[1]),
    .gpio_offset(off[1]), .bram_rd(rd_in[1]), .bram_adr(adr[1]), .bram_en(en[1]),
    .bram_we(we[1]), .bram_wd(wd[1]), .gpio_rd(grd[1]), .gpio_status(st[1])
  );

  // BRAM models: 1-cycle read for u0, 3-cycle read for u1.
  always @(posedge clk) begin
    if (en[0]) rd_in[0] <= mem[0][adr[0][4:2]];
    if (en[1]) q1a <= mem[1][adr[1][4:2]];
    q1b      <= q1a;
    rd_in[1] <= q1b;
    for (int k = 0; k < 2; k++) begin
      if (en[k]) fcnt[k] <= fcnt[k] + 1;
      if (we[k]) begin
        wcnt[k] <= wcnt[k] + 1;
        wadr[k] <= adr[k];
        wdat[k] <= wd[k];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Raise go with a command; check FETCH, exact completion cycle and result.
  task automatic do_cmd(input int k, input logic [7:0] c, input logic [7:0] m,
                        input logic [7:0] o, input logic [31:0] exp_adr,
                        input logic [31:0] exp_rd, input bit legal, input bit hold);
    int   f0;
    int   n;
    exp_t e;
    @(negedge clk);
    cmd[k]  = c;
    mult[k] = m;
    off[k]  = o;
    f0      = fcnt[k];
    e.rd    = exp_rd;
    e.st    = legal ? 3'b010 : 3'b110;
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    if (legal) begin
      check("fetch_status", st[k], 3'b001);
      check("fetch_en", en[k], 1);
      check("fetch_adr", adr[k], exp_adr);
      n = lat_of(k) + 1;
`ifdef GPIO_CMD_WRITEBACK_EN
      if (c[7:6] != 2'b00) n++;
`endif
      repeat (n - 1) @(posedge clk);
      #1;
      check("busy_before_done", st[k], 3'b001);
      @(posedge clk);
      #1;
    end
    e = sb.pop_front();
    check("result", grd[k], e.rd);
    check("status", st[k], e.st);
    check("fetch_count", fcnt[k] - f0, legal ? 1 : 0);
    if (!hold) begin
      @(negedge clk);
      cmd[k][0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("idle_status_kept", st[k], e.st);
    end
  endtask

  initial begin
    int f0;
    int w0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mem[k][i] = '0;
      rst_n[k] = 1'b0;
      cmd[k]   = '0;
      mult[k]  = '0;
      off[k]   = '0;
    end
    mem[0][2] = 32'h0000_00F0;
    mem[0][1] = 32'hFFFF_FFFE;
    mem[0][7] = 32'h1000_0001;
    mem[0][3] = 32'h1234_5678;
    mem[1][5] = 32'hA5A5_5A5A;
    mem[1][4] = 32'hCAFE_0004;

    repeat (2) @(posedge clk);
    #1;
    check("reset_status", st[0], 3'b000);
    check("reset_rd", grd[0], 32'h0);
    check("reset_adr", adr[0], 32'h0);
    check("reset_en", en[0], 0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(posedge clk);

    w0 = wcnt[0];
    do_cmd(0, 8'h51, 8'h00, 8'h00, 32'h08, 32'hFFFF_FF0F, 1, 0);
`ifdef GPIO_CMD_WRITEBACK_EN
    check("wb_count", wcnt[0] - w0, 1);
    check("wb_adr", wadr[0], 32'h08);
    check("wb_data", wdat[0], 32'hFFFF_FF0F);
`endif
    do_cmd(0, 8'h89, 8'h00, 8'h05, 32'h04, 32'h0000_0003, 1, 0);
    do_cmd(0, 8'hF9, 8'h20, 8'h00, 32'h1C, 32'h0000_0020, 1, 0);
    do_cmd(0, 8'hC9, 8'h03, 8'h00, 32'h04, 32'(mem[0][1] * 32'd3), 1, 0);

    // Go held high after completion must not retrigger.
    w0 = wcnt[0];
    do_cmd(0, 8'h19, 8'h00, 8'h00, 32'h0C, 32'h1234_5678, 1, 1);
    f0 = fcnt[0];
    repeat (10) @(posedge clk);
    #1;
    check("hold_no_refetch", fcnt[0] - f0, 0);
    check("hold_status", st[0], 3'b010);
    @(negedge clk);
    cmd[0][0] = 1'b0;
    repeat (4) @(posedge clk);
    do_cmd(0, 8'h19, 8'h00, 8'h00, 32'h0C, 32'h1234_5678, 1, 0);
    check("read_no_wb", wcnt[0] - w0, 0);

    // Instance 1: legal read, then an illegal index leaves gpio_rd alone.
    do_cmd(1, 8'h29, 8'h00, 8'h00, 32'h14, 32'hA5A5_5A5A, 1, 0);
    do_cmd(1, 8'h31, 8'h00, 8'h00, 32'h00, 32'hA5A5_5A5A, 0, 0);

    // Reset while in WAIT aborts immediately.
    @(negedge clk);
    cmd[1] = 8'h61;
    repeat (4) @(posedge clk);
    #1;
    check("wait_busy", st[1], 3'b001);
    #2;
    rst_n[1] = 1'b0;
    #1;
    check("abort_status", st[1], 3'b000);
    check("abort_rd", grd[1], 32'h0);
    check("abort_adr", adr[1], 32'h0);
    check("abort_en", en[1], 0);
    @(negedge clk);
    cmd[1]   = 8'h00;
    rst_n[1] = 1'b1;
    repeat (3) @(posedge clk);
    do_cmd(1, 8'h61, 8'h00, 8'h00, 32'h10, ~mem[1][4], 1, 0);

`ifndef GPIO_CMD_WRITEBACK_EN
    check("never_we", wcnt[0] + wcnt[1], 0);
`endif
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_cmd_engine.md
# gpio_cmd_engine

Parametrised command engine between the GPIO register interface and a single-port block RAM. Software writes a command word selecting an element index and an operation. The engine synchronises the GPIO inputs, fetches the addressed BRAM word, applies read/complement/offset/multiply and returns the result on `gpio_rd` with busy/done/error status. It succeeds the fixed 8-element datapath; width, depth, BRAM latency and optional write-back are now parameters.

## Interface
- `DATA_W`, 32, BRAM word and result width.
- `IDX_W`, 3, element index width; command width is `IDX_W+5`.
- `NUM_ELEM`, 8, valid elements (1..2^IDX_W); index >= NUM_ELEM is illegal.
- `BASE_ADDR`, 0, byte address of element 0.
- `STRIDE`, 4, byte stride between elements.
- `BRAM_LAT`, 1, BRAM read latency in cycles (>=1).
- `clk`  in  1  system clock, all logic rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `gpio_cmdreg`  in  IDX_W+5  bit0 go; [2:1] reserved; [IDX_W+2:3] index; [IDX_W+4:IDX_W+3] opcode.
- `gpio_mult`  in  8  multiplier, unsigned.
- `gpio_offset`  in  8  offset, unsigned.
- `bram_rd`  in  DATA_W  BRAM read data.
- `bram_adr`  out  32  BRAM byte address.
- `bram_en`  out  1  BRAM enable.
- `bram_we`  out  1  BRAM write strobe.
- `bram_wd`  out  DATA_W  BRAM write data.
- `gpio_rd`  out  DATA_W  last result.
- `gpio_status`  out  3  {err, done, busy}.

## Operation
- All GPIO inputs pass through two-flop synchronisers; only synchronised values are used. A third flop on go provides edge detection.
- Command accepted only in IDLE on a rising edge of synchronised go. Index, opcode, mult and offset are latched at acceptance and not re-sampled.
- Acceptance clears done and err and sets busy.
- Illegal index: go directly to DONE, set err=1 and done=1, no BRAM access, `gpio_rd` unchanged.
- States:
  - IDLE: wait for an accepted command.
  - FETCH: 1 cycle; `bram_en`=1, `bram_adr`=BASE_ADDR+idx*STRIDE.
  - WAIT: BRAM_LAT-1 cycles, skipped if BRAM_LAT=1.
  - EXEC: sample `bram_rd`, register the result into `gpio_rd`.
  - WB: macro only.
  - DONE: busy=0, done=1; return to IDLE when synchronised go=0.
- Opcodes:
  - 00 read: result = data.
  - 01 complement: result = ~data.
  - 10 offset: result = data + zero-extended offset, modulo 2^DATA_W.
  - 11 multiply: result = low DATA_W bits of data*mult.
- Go falling mid-operation is ignored; the operation completes. done and err stay set in IDLE until the next acceptance.
- Go held high after completion does not retrigger; it must drop, then rise again.
- `bram_adr` holds its last value outside FETCH/WB; `bram_en` is 0 outside FETCH/WB.

## Timing
- Reset (asynchronous, takes effect immediately): state IDLE, `bram_adr`=0, `bram_en`=0, `bram_we`=0, `bram_wd`=0, `gpio_rd`=0, `gpio_status`=0, synchronisers cleared. Reset mid-operation aborts it with no partial result.
- Go edge to acceptance: 3 clk (2 sync + edge detect).
- Acceptance at cycle t:
  - FETCH at t+1.
  - EXEC at t+1+BRAM_LAT.
  - `gpio_rd` and done visible at t+2+BRAM_LAT (t+3+BRAM_LAT with write-back).
- Illegal index: done and err visible at t+1.
- busy is high from t+1 until done rises.

## Configuration
- `GPIO_CMD_WRITEBACK_EN` defined: WB state follows EXEC for 1 cycle with `bram_en`=1, `bram_we`=1, same address, `bram_wd`=result. Opcode 00 skips WB.
- Macro undefined: no WB state; `bram_we` and `bram_wd` are tied to 0.

## Test plan
- Word 0x0000_00F0 at byte 0x08, cmd 0x51 (complement, idx 2) -> `bram_adr`=0x08 in FETCH; `gpio_rd`=0xFFFF_FF0F; status 3'b010 at t+3.
- Word 0xFFFF_FFFE at 0x04, offset 0x05, cmd 0x89 -> `gpio_rd`=0x0000_0003 (wrap).
- Word 0x1000_0001 at 0x1C, mult 0x20, cmd 0xF9 -> `gpio_rd`=0x0000_0020 (truncated).
- NUM_ELEM=6, cmd 0x31 (read, idx 6) -> err=1, done=1, `bram_en` never high, `gpio_rd` unchanged.
- Go held at 1 after done -> no second FETCH; drop go then raise it -> exactly one further FETCH.
- BRAM_LAT=3, reset asserted in WAIT -> all outputs 0 immediately; the next command runs normally.
- With `GPIO_CMD_WRITEBACK_EN`, cmd 0x51 -> one-cycle `bram_we` at 0x08 with `bram_wd`=0xFFFF_FF0F; cmd 0x01 -> no `bram_we`.
